// File: rtl/game_pkg.sv
// Shared types and constants for the breakout game-flow controller and its score counter.
package game_pkg;

    typedef enum logic [2:0] {
        GS_IDLE      = 3'd0,
        GS_SERVE     = 3'd1,
        GS_PLAY      = 3'd2,
        GS_LIFE_LOST = 3'd3,
        GS_GAME_OVER = 3'd4,
        GS_WIN       = 3'd5
    } game_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int NUM_ROWS           = 5;
    localparam int NUM_COLS           = 12;
    localparam int DEFAULT_INIT_LIVES = 9;
    localparam int MAX_LIVES          = 9;

endpackage

// File: rtl/game_sequencer_bcd_score_counter.sv
// Two-digit BCD score counter saturating at 99, with a parallel binary total.
module bcd_score_counter
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output bcd_digit_t ones,
    output bcd_digit_t tens,
    output logic [6:0] total,
    output logic       at_max
);

    bcd_digit_t ones_reg;
    bcd_digit_t tens_reg;
    logic [6:0] total_reg;

    assign at_max = (tens_reg == 4'd9) && (ones_reg == 4'd9);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ones_reg  <= '0;
            tens_reg  <= '0;
            total_reg <= '0;
        end else if (inc && !at_max) begin
            total_reg <= total_reg + 7'd1;
            if (ones_reg == 4'd9) begin
                ones_reg <= '0;
                tens_reg <= tens_reg + 4'd1;
            end else begin
                ones_reg <= ones_reg + 4'd1;
            end
        end
    end

    assign ones  = ones_reg;
    assign tens  = tens_reg;
    assign total = total_reg;

endmodule

// File: rtl/game_sequencer.sv
// Breakout game-flow controller: phase FSM, lives and block bookkeeping, BCD score.
// Optional bonus-life feature enabled by defining BONUS_LIFE_EN.
module game_sequencer
    import game_pkg::*;
#(
    parameter int INIT_LIVES   = DEFAULT_INIT_LIVES,
    parameter int NUM_BLOCKS   = NUM_ROWS * NUM_COLS,
    parameter int SERVE_FRAMES = 60,
    parameter int LOSS_FRAMES  = 90,
    parameter int BONUS_STEP   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       block_hit,
    input  logic       floor_hit,
    output logic       ball_reset,
    output logic       ball_en,
    output logic       paddle_en,
    output logic       grid_reset,
    output logic [2:0] state,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic [3:0] lives,
    output logic [6:0] blocks_left
);

    localparam logic [2:0] S_IDLE      = GS_IDLE;
    localparam logic [2:0] S_SERVE     = GS_SERVE;
    localparam logic [2:0] S_PLAY      = GS_PLAY;
    localparam logic [2:0] S_LIFE_LOST = GS_LIFE_LOST;
    localparam logic [2:0] S_GAME_OVER = GS_GAME_OVER;
    localparam logic [2:0] S_WIN       = GS_WIN;

    localparam int CNT_MAX = (SERVE_FRAMES > LOSS_FRAMES) ? SERVE_FRAMES : LOSS_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       lives_reg, lives_next;
    logic [6:0]       blocks_reg, blocks_next;
    logic             ball_reset_reg, ball_reset_next;
    logic             grid_reset_reg, grid_reset_next;
    logic             ball_en_reg, paddle_en_reg;
    logic             start_q_reg;
    logic             start_rise, new_game;
    logic             score_inc, score_clr;
    logic [6:0]       score_total;
    logic             score_at_max;
    logic             bonus_hit;

    assign start_rise = start && !start_q_reg;

    bcd_score_counter u_score (
        .clk    (clk),
        .rst    (rst),
        .clr    (score_clr),
        .inc    (score_inc),
        .ones   (score_ones),
        .tens   (score_tens),
        .total  (score_total),
        .at_max (score_at_max)
    );

`ifdef BONUS_LIFE_EN
    // Bonus fires when this hit lands the binary total on a multiple of BONUS_STEP.
    assign bonus_hit = !score_at_max && (((int'(score_total) + 1) % BONUS_STEP) == 0);
`else
    logic unused_bonus_cfg;
    assign unused_bonus_cfg = ^{score_total, score_at_max, 32'(BONUS_STEP)};
    assign bonus_hit = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        lives_next      = lives_reg;
        blocks_next     = blocks_reg;
        ball_reset_next = 1'b0;
        grid_reset_next = 1'b0;
        score_inc       = 1'b0;
        score_clr       = 1'b0;
        new_game        = 1'b0;

        case (state_reg)
            S_IDLE: new_game = start;
            S_SERVE: begin
                if (frame_tick) cnt_next = cnt_reg + 1'b1;
                // Early serve needs at least one elapsed frame so the start press that began the game cannot launch it.
                if ((frame_tick && cnt_reg == CNT_W'(SERVE_FRAMES - 1)) ||
                    (start_rise && cnt_reg != '0))
                    state_next = S_PLAY;
            end
            S_PLAY: begin
                if (block_hit) begin
                    score_inc = 1'b1;
                    if (blocks_reg != '0) blocks_next = blocks_reg - 7'd1;
                    if (bonus_hit && lives_reg < 4'(MAX_LIVES)) lives_next = lives_reg + 4'd1;
                    if (blocks_reg == 7'd1) state_next = S_WIN;
                end
                // A hit that clears the grid wins outright and masks a same-cycle floor hit.
                if (floor_hit && !(block_hit && blocks_reg == 7'd1)) begin
                    cnt_next   = '0;
                    state_next = (lives_next <= 4'd1) ? S_GAME_OVER : S_LIFE_LOST;
                    if (lives_next != '0) lives_next = lives_next - 4'd1;
                end
            end
            S_LIFE_LOST: begin
                if (frame_tick) begin
                    if (cnt_reg == CNT_W'(LOSS_FRAMES - 1)) begin
                        state_next      = S_SERVE;
                        ball_reset_next = 1'b1;
                        cnt_next        = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            S_GAME_OVER, S_WIN: new_game = start_rise;
            default: state_next = S_IDLE;
        endcase

        if (new_game) begin
            state_next      = S_SERVE;
            cnt_next        = '0;
            lives_next      = 4'(INIT_LIVES);
            blocks_next     = 7'(NUM_BLOCKS);
            ball_reset_next = 1'b1;
            grid_reset_next = 1'b1;
            score_clr       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            lives_reg      <= 4'(INIT_LIVES);
            blocks_reg     <= 7'(NUM_BLOCKS);
            ball_reset_reg <= 1'b0;
            grid_reset_reg <= 1'b0;
            ball_en_reg    <= 1'b0;
            paddle_en_reg  <= 1'b0;
            start_q_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            lives_reg      <= lives_next;
            blocks_reg     <= blocks_next;
            ball_reset_reg <= ball_reset_next;
            grid_reset_reg <= grid_reset_next;
            ball_en_reg    <= (state_next == S_PLAY);
            paddle_en_reg  <= (state_next == S_PLAY) || (state_next == S_SERVE);
            start_q_reg    <= start;
        end
    end

    assign state       = state_reg;
    assign lives       = lives_reg;
    assign blocks_left = blocks_reg;
    assign ball_reset  = ball_reset_reg;
    assign grid_reset  = grid_reset_reg;
    assign ball_en     = ball_en_reg;
    assign paddle_en   = paddle_en_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: default-parameter instance plus a large-grid, short-timer instance.
module tb_game_sequencer;

    logic clk = 1'b0;
    logic rst, start, frame_tick, block_hit, floor_hit;

    logic       br, be, pe, gr;
    logic [2:0] st;
    logic [3:0] ones, tens, lv;
    logic [6:0] blk;

    logic       b_br, b_be, b_pe, b_gr;
    logic [2:0] b_st;
    logic [3:0] b_ones, b_tens, b_lv;
    logic [6:0] b_blk;

    int n_cmp = 0;
    int n_bad = 0;
    int lb;

    always #5 clk = ~clk;

    game_sequencer u_dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .block_hit(block_hit), .floor_hit(floor_hit),
        .ball_reset(br), .ball_en(be), .paddle_en(pe), .grid_reset(gr),
        .state(st), .score_ones(ones), .score_tens(tens), .lives(lv), .blocks_left(blk)
    );

    game_sequencer #(.NUM_BLOCKS(120), .SERVE_FRAMES(2), .LOSS_FRAMES(2)) u_big (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .block_hit(block_hit), .floor_hit(floor_hit),
        .ball_reset(b_br), .ball_en(b_be), .paddle_en(b_pe), .grid_reset(b_gr),
        .state(b_st), .score_ones(b_ones), .score_tens(b_tens), .lives(b_lv), .blocks_left(b_blk)
    );

    typedef struct {
        string name;
        int rst, start, ft, bh, fh, reps;
        int st, br, gr, be, pe, tens, ones, lives, blocks;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input int r, input int s, input int f, input int b, input int fl, input int n);
        rst        = (r != 0);
        start      = (s != 0);
        frame_tick = (f != 0);
        block_hit  = (b != 0);
        floor_hit  = (fl != 0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        drive(v.rst, v.start, v.ft, v.bh, v.fh, v.reps);
        $display("[%0t] %s: state=%0d br=%0d gr=%0d be=%0d pe=%0d score=%0d%0d lives=%0d blocks=%0d",
                 $time, v.name, st, br, gr, be, pe, tens, ones, lv, blk);
        check({v.name, ".state"},      32'(st),   v.st);
        check({v.name, ".ball_reset"}, 32'(br),   v.br);
        check({v.name, ".grid_reset"}, 32'(gr),   v.gr);
        check({v.name, ".ball_en"},    32'(be),   v.be);
        check({v.name, ".paddle_en"},  32'(pe),   v.pe);
        check({v.name, ".score_tens"}, 32'(tens), v.tens);
        check({v.name, ".score_ones"}, 32'(ones), v.ones);
        check({v.name, ".lives"},      32'(lv),   v.lives);
        check({v.name, ".blocks"},     32'(blk),  v.blocks);
    endtask

    task automatic big_step(input string name, input int f, input int b, input int fl, input int n,
                            input int e_st, input int e_br, input int e_tens, input int e_ones,
                            input int e_lv, input int e_blk);
        drive(0, 0, f, b, fl, n);
        $display("[%0t] big.%s: state=%0d br=%0d score=%0d%0d lives=%0d blocks=%0d",
                 $time, name, b_st, b_br, b_tens, b_ones, b_lv, b_blk);
        check({"big.", name, ".state"}, 32'(b_st),   e_st);
        check({"big.", name, ".ball_reset"}, 32'(b_br), e_br);
        check({"big.", name, ".tens"},  32'(b_tens), e_tens);
        check({"big.", name, ".ones"},  32'(b_ones), e_ones);
        check({"big.", name, ".lives"}, 32'(b_lv),   e_lv);
        check({"big.", name, ".blocks"}, 32'(b_blk), e_blk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; frame_tick = 1'b0; block_hit = 1'b0; floor_hit = 1'b0;
`ifdef BONUS_LIFE_EN
        lb = 9;
`else
        lb = 8;
`endif
        //            name            rst st ft bh fh reps  st br gr be pe tn on lv blk
        vecs[0]  = '{"reset",          1, 0, 0, 0, 0, 2,    0, 0, 0, 0, 0, 0, 0, 9, 60};
        vecs[1]  = '{"start",          0, 1, 0, 0, 0, 1,    1, 1, 1, 0, 1, 0, 0, 9, 60};
        vecs[2]  = '{"serve_idle",     0, 0, 0, 0, 0, 1,    1, 0, 0, 0, 1, 0, 0, 9, 60};
        vecs[3]  = '{"serve_hit_ign",  0, 0, 0, 1, 0, 1,    1, 0, 0, 0, 1, 0, 0, 9, 60};
        vecs[4]  = '{"serve_59",       0, 0, 1, 0, 0, 59,   1, 0, 0, 0, 1, 0, 0, 9, 60};
        vecs[5]  = '{"serve_60",       0, 0, 1, 0, 0, 1,    2, 0, 0, 1, 1, 0, 0, 9, 60};
        vecs[6]  = '{"hits_13",        0, 0, 0, 1, 0, 13,   2, 0, 0, 1, 1, 1, 3, 9, 47};
        vecs[7]  = '{"floor",          0, 0, 0, 0, 1, 1,    3, 0, 0, 0, 0, 1, 3, 8, 47};
        vecs[8]  = '{"loss_89",        0, 0, 1, 0, 0, 89,   3, 0, 0, 0, 0, 1, 3, 8, 47};
        vecs[9]  = '{"loss_90",        0, 0, 1, 0, 0, 1,    1, 1, 0, 0, 1, 1, 3, 8, 47};
        vecs[10] = '{"reserve_idle",   0, 0, 0, 0, 0, 1,    1, 0, 0, 0, 1, 1, 3, 8, 47};
        vecs[11] = '{"reserve_tick",   0, 0, 1, 0, 0, 1,    1, 0, 0, 0, 1, 1, 3, 8, 47};
        vecs[12] = '{"early_launch",   0, 1, 0, 0, 0, 1,    2, 0, 0, 1, 1, 1, 3, 8, 47};
        vecs[13] = '{"hit_and_floor",  0, 0, 0, 1, 1, 1,    3, 0, 0, 0, 0, 1, 4, 7, 46};
        vecs[14] = '{"loss_45",        0, 0, 1, 0, 0, 45,   3, 0, 0, 0, 0, 1, 4, 7, 46};
        vecs[15] = '{"rst_mid_loss",   1, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0, 0, 9, 60};
        vecs[16] = '{"idle_after_rst", 0, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0, 0, 9, 60};

        for (int i = 0; i < 17; i++) run_vec(vecs[i]);

        // Lose every life down to game over, then restart from GAME_OVER.
        run_vec('{"go_start", 0, 1, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 0, 9, 60});
        for (int k = 9; k >= 2; k--) begin
            run_vec('{"go_serve", 0, 0, 1, 0, 0, 60, 2, 0, 0, 1, 1, 0, 0, k, 60});
            run_vec('{"go_floor", 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, k - 1, 60});
            run_vec('{"go_wait", 0, 0, 1, 0, 0, 90, 1, 1, 0, 0, 1, 0, 0, k - 1, 60});
        end
        run_vec('{"go_last_serve", 0, 0, 1, 0, 0, 60, 2, 0, 0, 1, 1, 0, 0, 1, 60});
        run_vec('{"game_over",     0, 0, 0, 0, 1, 1,  4, 0, 0, 0, 0, 0, 0, 0, 60});
        run_vec('{"go_ignore",     0, 0, 0, 1, 1, 1,  4, 0, 0, 0, 0, 0, 0, 0, 60});
        run_vec('{"go_restart",    0, 1, 0, 0, 0, 1,  1, 1, 1, 0, 1, 0, 0, 9, 60});

        // Clear the grid with a simultaneous floor hit on the last block.
        run_vec('{"win_serve",   0, 0, 1, 0, 0, 60, 2, 0, 0, 1, 1, 0, 0, 9, 60});
        run_vec('{"win_hits",    0, 0, 0, 1, 0, 59, 2, 0, 0, 1, 1, 5, 9, 9, 1});
        run_vec('{"win_last",    0, 0, 0, 1, 1, 1,  5, 0, 0, 0, 0, 6, 0, 9, 0});
        run_vec('{"win_ignore",  0, 0, 1, 1, 1, 1,  5, 0, 0, 0, 0, 6, 0, 9, 0});
        run_vec('{"win_restart", 0, 1, 0, 0, 0, 1,  1, 1, 1, 0, 1, 0, 0, 9, 60});

        // Large-grid instance: bonus life and score saturation.
        drive(1, 0, 0, 0, 0, 2);
        drive(0, 1, 0, 0, 0, 1);
        big_step("serve",     1, 0, 0, 2,  2, 0, 0, 0, 9, 120);
        big_step("floor",     0, 0, 1, 1,  3, 0, 0, 0, 8, 120);
        big_step("reserve",   1, 0, 0, 2,  1, 1, 0, 0, 8, 120);
        big_step("relaunch",  1, 0, 0, 2,  2, 0, 0, 0, 8, 120);
        big_step("hits_19",   0, 1, 0, 19, 2, 0, 1, 9, 8, 101);
        big_step("hit_20",    0, 1, 0, 1,  2, 0, 2, 0, lb, 100);
        big_step("hits_40",   0, 1, 0, 20, 2, 0, 4, 0, lb, 80);
        big_step("hits_99",   0, 1, 0, 59, 2, 0, 9, 9, lb, 21);
        big_step("hit_sat",   0, 1, 0, 1,  2, 0, 9, 9, lb, 20);
        drive(0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
